cpu_trace_buffer: RTL and testbench

Capture-and-drain trace unit on the CPU's observation outputs: instruction address (32 b), opcode (6 b) and ALU result (32 b). After an arm pulse it waits for an optional opcode trigger, then records one entry per clock into a DEPTH-entry circular FIFO. A bench or debug host drains the entries through a valid/ready read port. It sits beside the CPU top level as the consumer of the signals the CPU drives out, so stimulus checks no longer depend on waveform inspection.

---
 rtl/cpu_trace_buffer.sv | 150 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Trace capture unit: arm/trigger FSM feeding a DEPTH-entry circular FIFO of
// {pc, opcode, result} samples, drained through a show-ahead valid/ready port.
module cpu_trace_buffer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int POST_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic              trig_en,
  input  logic [5:0]        trig_op,
  input  logic [31:0]       pc_in,
  input  logic [5:0]        op_in,
  input  logic [31:0]       res_in,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_pc,
  output logic [5:0]        rd_op,
  output logic [31:0]       rd_res,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        ovf_cnt,
  output logic [1:0]        state
);

  // state   | meaning
  // IDLE    | no session; FIFO may still be drained
  // ARMED   | waiting for the opcode trigger
  // CAPTURE | one push attempt per cycle until POST_CNT attempts
  // DONE    | session complete; arm starts a new one
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [7:0]      LP_POST  = 8'(POST_CNT);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [7:0]        r_att;
  logic [7:0]        w_att_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [7:0]        r_ovf;
  logic [31:0]       r_mem_pc  [DEPTH];
  logic [5:0]        r_mem_op  [DEPTH];
  logic [31:0]       r_mem_res [DEPTH];

  logic w_trig;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_drop;
  logic w_enter_armed;

  assign w_trig        = !trig_en || (op_in == trig_op);
  assign w_push        = !stop && (((r_state == S_ARMED) && w_trig) || (r_state == S_CAPTURE));
  assign w_pop         = (r_count != '0) && rd_ready;
  assign w_full        = (r_count == LP_DEPTH);
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_wr          = w_push && (!w_full || w_pop);
  assign w_drop        = w_push && w_full && !w_pop;
  assign w_enter_armed = !stop && arm && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_att_nxt     = (r_state == S_ARMED) ? 8'd1 : (r_att + 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (arm) w_state_nxt = S_ARMED;
        S_ARMED:   if (w_trig) w_state_nxt = (w_att_nxt == LP_POST) ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (w_att_nxt == LP_POST) w_state_nxt = S_DONE;
        S_DONE:    if (arm) w_state_nxt = S_ARMED;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state    = r_state;
    count    = r_count;
    ovf_cnt  = r_ovf;
    rd_valid = (r_count != '0);
    rd_pc    = r_mem_pc[r_rd_ptr];
    rd_op    = r_mem_op[r_rd_ptr];
    rd_res   = r_mem_res[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_att <= '0;
    end else if (w_enter_armed) begin
      r_att <= '0;
    end else if (w_push) begin
      r_att <= w_att_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (w_enter_armed && (r_state == S_DONE)) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]  <= '0;
        r_mem_op[i]  <= '0;
        r_mem_res[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem_pc[r_wr_ptr]  <= pc_in;
      r_mem_op[r_wr_ptr]  <= op_in;
      r_mem_res[r_wr_ptr] <= res_in;
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a queue-based session model predicts
// stored entries; a negedge monitor checks the read port and status outputs.
module tb_cpu_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int P      = 20;

  logic clk = 1'b0;
  logic rst, arm, stop, trig_en, rd_ready;
  logic [5:0] trig_op, op_in;
  logic [31:0] pc_in, res_in;
  logic rd_valid;
  logic [31:0] rd_pc, rd_res;
  logic [5:0] rd_op;
  logic [ADDR_W:0] count;
  logic [7:0] ovf_cnt;
  logic [1:0] state;

  cpu_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_CNT(P)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_op(trig_op), .pc_in(pc_in), .op_in(op_in), .res_in(res_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_op(rd_op),
    .rd_res(rd_res), .count(count), .ovf_cnt(ovf_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] res;
  } ent_t;

  ent_t exp_q[$];
  int total = 0;
  int bad = 0;
  int m_state = 0;
  int m_att = 0;
  int m_ovf = 0;
  bit mon_popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status every cycle; head entry compared and retired on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      mon_popped = 0;
      chk("state", 64'(state), 64'(m_state));
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
      chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
      if (exp_q.size() != 0 && rd_ready) begin
        chk("rd_pc", 64'(rd_pc), 64'(exp_q[0].pc));
        chk("rd_op", 64'(rd_op), 64'(exp_q[0].op));
        chk("rd_res", 64'(rd_res), 64'(exp_q[0].res));
        void'(exp_q.pop_front());
        mon_popped = 1;
      end
    end
  end

  // Session model: one push attempt per capture cycle, drops only when full and not draining.
  task automatic attempt(input int held_before);
    ent_t e;
    if (held_before < DEPTH || mon_popped) begin
      e.pc = pc_in; e.op = op_in; e.res = res_in;
      exp_q.push_back(e);
    end else if (m_ovf < 255) begin
      m_ovf++;
    end
  endtask

  task automatic model_step();
    int held_before;
    held_before = exp_q.size() + (mon_popped ? 1 : 0);
    if (stop) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; m_att = 0; end
        3: if (arm) begin m_state = 1; m_att = 0; m_ovf = 0; end
        1: if (!trig_en || op_in == trig_op) begin
             attempt(held_before);
             m_att = 1;
             m_state = (m_att == P) ? 3 : 2;
           end
        default: begin
          attempt(held_before);
          m_att++;
          if (m_att == P) m_state = 3;
        end
      endcase
    end
  endtask

  task automatic cyc(input logic a, input logic s, input logic te, input logic [5:0] top,
                     input logic [5:0] op, input logic [31:0] pc, input logic [31:0] res,
                     input logic rr);
    arm = a; stop = s; trig_en = te; trig_op = top; op_in = op;
    pc_in = pc; res_in = res; rd_ready = rr;
    @(negedge clk); #1;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 6'h0, 6'h0, 32'h0, 32'h0, rr);
  endtask

  task automatic drain_all();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4 * DEPTH) begin
      idle(1, 1);
      guard++;
    end
    chk("drain_bound", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_pc", 64'(rd_pc), 64'd0);
    chk("rst_op", 64'(rd_op), 64'd0);
    chk("rst_res", 64'(rd_res), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    exp_q.delete();
    m_state = 0; m_att = 0; m_ovf = 0; mon_popped = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 0; stop = 0; trig_en = 0; trig_op = 0; op_in = 0;
    pc_in = 0; res_in = 0; rd_ready = 0;
    #1;
    chk("init_state", 64'(state), 64'd0);
    chk("init_count", 64'(count), 64'd0);
    chk("init_valid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1);

    // Immediate trigger, no draining: first DEPTH samples kept, remainder dropped.
    cyc(1, 0, 0, 6'h0, 6'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < P; i++)
      cyc(0, 0, 0, 6'h0, 6'($urandom_range(0, 63)), 32'h100 + 32'(4 * i), $urandom, 0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ovf", 64'(ovf_cnt), 64'd4);
    chk("full_state", 64'(state), 64'd3);
    chk("full_head", 64'(rd_pc), 64'h100);
    drain_all();
    chk("drained_valid", 64'(rd_valid), 64'd0);

    // Opcode trigger: five non-matching cycles push nothing.
    cyc(1, 0, 1, 6'h23, 6'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 6'h23, 6'h0, 32'h200 + 32'(i), 32'h0, 0);
    chk("pretrig_count", 64'(count), 64'd0);
    chk("pretrig_state", 64'(state), 64'd1);
    chk("rearm_ovf", 64'(ovf_cnt), 64'd0);
    cyc(0, 0, 1, 6'h23, 6'h23, 32'h300, 32'hABCD, 0);
    chk("trig_op_head", 64'(rd_op), 64'h23);
    for (int i = 1; i < P; i++) cyc(0, 0, 1, 6'h23, 6'(i), 32'h300 + 32'(i), $urandom, 1);
    drain_all();

    // Full FIFO with continuous draining during capture: nothing dropped.
    cyc(1, 0, 0, 6'h0, 6'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < P; i++) cyc(0, 0, 0, 6'h0, 6'h1, 32'h400 + 32'(i), $urandom, 0);
    cyc(1, 0, 0, 6'h0, 6'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < P; i++) cyc(0, 0, 0, 6'h0, 6'h2, 32'h500 + 32'(i), $urandom, 1);
    chk("stream_ovf", 64'(ovf_cnt), 64'd0);
    chk("stream_count", 64'(count), 64'd16);
    drain_all();

    // stop together with arm mid-capture: back to IDLE, contents kept.
    cyc(1, 0, 0, 6'h0, 6'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 6'h0, 6'h3, 32'h600 + 32'(i), $urandom, 0);
    cyc(1, 1, 0, 6'h0, 6'h3, 32'h6FF, 32'h0, 0);
    chk("stop_state", 64'(state), 64'd0);
    chk("stop_count", 64'(count), 64'd5);
    idle(3, 0);
    chk("stop_hold", 64'(count), 64'd5);
    drain_all();

    // Asynchronous reset with a partly full FIFO mid-capture.
    cyc(1, 0, 0, 6'h0, 6'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 6'h0, 6'h4, 32'h700 + 32'(i), $urandom, 0);
    #2;
    do_reset();
    idle(3, 1);
    chk("post_rst_idle", 64'(state), 64'd0);

    // Random sessions.
    trig_op = 6'($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0), 1'($urandom),
          trig_op, 6'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
    end
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
